// File: rtl/cpu_stack_file.sv
// Operand-stack register file: one commit per cycle (pop N, optional push), registered
// top-of-stack view with per-entry valid bits, occupancy, flush and sticky error flags.
module cpu_stack_file #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 64,
    parameter int POP_W  = 11,
    parameter int READ_N = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       commit,
    input  logic [POP_W-1:0]           pop_cnt,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    output logic [READ_N*DATA_W-1:0]   top_data,
    output logic [READ_N-1:0]          top_valid,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ((POP_W > DW) ? POP_W : DW) + 1;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [CW-1:0]            k_ext;
    logic [CW-1:0]            d_ext;
    logic [CW-1:0]            d1;
    logic [CW-1:0]            nd_ext;
    logic [DW-1:0]            nd;
    logic                     under;
    logic                     wr;
    logic                     drop;
    logic [AW-1:0]            idx;
    logic [READ_N*DATA_W-1:0] top_next;
    logic [READ_N-1:0]        valid_next;

    always_comb begin
        k_ext  = CW'(pop_cnt);
        d_ext  = CW'(depth);
        under  = k_ext > d_ext;
        d1     = under ? '0 : d_ext - k_ext;
        wr     = push && (d1 < CW'(DEPTH));
        drop   = push && !wr;
        nd_ext = wr ? d1 + CW'(1) : d1;
        nd     = DW'(nd_ext);

        // The post-commit view is built here so the outputs can be registered;
        // a slot being written this cycle is forwarded from push_data.
        top_next   = '0;
        valid_next = '0;
        idx        = '0;
        for (int unsigned i = 0; i < READ_N; i++) begin
            if (DW'(i) < nd) begin
                idx           = AW'(nd - DW'(1) - DW'(i));
                valid_next[i] = 1'b1;
                if (wr && (CW'(idx) == d1))
                    top_next[i*DATA_W +: DATA_W] = push_data;
                else
                    top_next[i*DATA_W +: DATA_W] = mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            depth     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            top_valid <= '0;
            top_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (commit) begin
            depth     <= nd;
            empty     <= (nd == '0);
            full      <= (nd == DW'(DEPTH));
            top_valid <= valid_next;
            top_data  <= top_next;
            if (under)
                underflow <= 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && commit && wr)
            mem[AW'(d1)] <= push_data;
    end

endmodule

// File: tb/tb_cpu_stack_file.sv
// Scoreboard bench for cpu_stack_file: directed commits with hand-computed expected
// stack views, checked on two instances (READ_N=2 and READ_N=3, DEPTH=4).
module tb_cpu_stack_file;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         commit = 1'b0;
    logic [10:0]  pop_cnt = '0;
    logic         push = 1'b0;
    logic [34:0]  push_data = '0;

    logic [69:0]  top_data_a;
    logic [1:0]   top_valid_a;
    logic [2:0]   depth_a;
    logic         empty_a, full_a, overflow_a, underflow_a;

    logic [104:0] top_data_b;
    logic [2:0]   top_valid_b;
    logic [2:0]   depth_b;
    logic         empty_b, full_b, overflow_b, underflow_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          d;
        logic [34:0] e0, e1, e2;
        logic        ov, un;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    cpu_stack_file #(.DATA_W(35), .DEPTH(4), .POP_W(11), .READ_N(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .commit(commit), .pop_cnt(pop_cnt),
        .push(push), .push_data(push_data), .top_data(top_data_a), .top_valid(top_valid_a),
        .depth(depth_a), .empty(empty_a), .full(full_a), .overflow(overflow_a),
        .underflow(underflow_a)
    );

    cpu_stack_file #(.DATA_W(35), .DEPTH(4), .POP_W(11), .READ_N(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .commit(commit), .pop_cnt(pop_cnt),
        .push(push), .push_data(push_data), .top_data(top_data_b), .top_valid(top_valid_b),
        .depth(depth_b), .empty(empty_b), .full(full_b), .overflow(overflow_b),
        .underflow(underflow_b)
    );

    task automatic chk(input string name, input int step, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s actual=%0h required=%0h", step, name, act, req);
        end
    endtask

    int step = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [2:0] vm;
            e = q.pop_front();
            step++;
            vm = '0;
            for (int i = 0; i < 3; i++)
                if (i < e.d) vm[i] = 1'b1;
            chk("depth_a",     step, 128'(depth_a),     128'(e.d));
            chk("empty_a",     step, 128'(empty_a),     128'(e.d == 0));
            chk("full_a",      step, 128'(full_a),      128'(e.d == 4));
            chk("overflow_a",  step, 128'(overflow_a),  128'(e.ov));
            chk("underflow_a", step, 128'(underflow_a), 128'(e.un));
            chk("top_valid_a", step, 128'(top_valid_a), 128'(vm[1:0]));
            chk("top_data_a",  step, 128'(top_data_a),  128'({e.e1, e.e0}));
            chk("depth_b",     step, 128'(depth_b),     128'(e.d));
            chk("overflow_b",  step, 128'(overflow_b),  128'(e.ov));
            chk("underflow_b", step, 128'(underflow_b), 128'(e.un));
            chk("top_valid_b", step, 128'(top_valid_b), 128'(vm));
            chk("top_data_b",  step, 128'(top_data_b),  128'({e.e2, e.e1, e.e0}));
        end
    end

    task automatic op(input logic r, input logic f, input logic c, input logic [10:0] k,
                      input logic p, input logic [34:0] dat, input int ed,
                      input logic [34:0] e0, input logic [34:0] e1, input logic [34:0] e2,
                      input logic eo, input logic eu);
        exp_t e;
        rst = r; flush = f; commit = c; pop_cnt = k; push = p; push_data = dat;
        @(posedge clk);
        #1;
        e.d = ed; e.e0 = e0; e.e1 = e1; e.e2 = e2; e.ov = eo; e.un = eu;
        q.push_back(e);
    endtask

    initial begin
        int wait_cnt;
        // reset state
        op(1,0,0,0,    0,35'h0,  0, 35'h0, 35'h0, 35'h0, 0,0);
        // push 1,2,3
        op(0,0,1,0,    1,35'h1,  1, 35'h1, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h2,  2, 35'h2, 35'h1, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h3,  3, 35'h3, 35'h2, 35'h1, 0,0);
        // pop 2 + push 7
        op(0,0,1,2,    1,35'h7,  2, 35'h7, 35'h1, 35'h0, 0,0);
        // flush, then fill past capacity
        op(0,1,0,0,    0,35'h0,  0, 35'h0, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'hA,  1, 35'hA, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'hB,  2, 35'hB, 35'hA, 35'h0, 0,0);
        op(0,0,1,0,    1,35'hC,  3, 35'hC, 35'hB, 35'hA, 0,0);
        op(0,0,1,0,    1,35'hD,  4, 35'hD, 35'hC, 35'hB, 0,0);
        op(0,0,1,0,    1,35'hE,  4, 35'hD, 35'hC, 35'hB, 1,0);
        op(0,0,1,1,    0,35'h0,  3, 35'hC, 35'hB, 35'hA, 1,0);
        // commit low: everything held, push ignored
        op(0,0,0,3,    1,35'h3F, 3, 35'hC, 35'hB, 35'hA, 1,0);
        // pop 1 + push replaces TOS
        op(0,0,1,1,    1,35'h1F, 3, 35'h1F,35'hB, 35'hA, 1,0);
        // flush beats commit
        op(0,1,1,0,    1,35'h9,  0, 35'h0, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h11, 1, 35'h11,35'h0, 35'h0, 0,0);
        // huge pop count: underflow, no wrap
        op(0,0,1,11'h7FF,0,35'h0, 0, 35'h0, 35'h0, 35'h0, 0,1);
        // underflow again with push lands at index 0
        op(0,0,1,1,    1,35'h22, 1, 35'h22,35'h0, 35'h0, 0,1);
        op(0,1,0,0,    0,35'h0,  0, 35'h0, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h1,  1, 35'h1, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h2,  2, 35'h2, 35'h1, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h3,  3, 35'h3, 35'h2, 35'h1, 0,0);
        // reset beats commit
        op(1,0,1,0,    1,35'h9,  0, 35'h0, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h5,  1, 35'h5, 35'h0, 35'h0, 0,0);
        op(0,0,1,0,    1,35'h4,  2, 35'h4, 35'h5, 35'h0, 0,0);
        // pop count above DEPTH with push
        op(0,0,1,5,    1,35'h6,  1, 35'h6, 35'h0, 35'h0, 0,1);
        rst = 1'b0; flush = 1'b0; commit = 1'b0; push = 1'b0; pop_cnt = '0;

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
